// File: rtl/ram_master.sv
// ram_master: turns single client requests into transactions on a
// negedge-sampled memory bus. It registers the bus, waits for the memory's
// busy/done handshake, reports a completion pulse, and recovers through a
// settle phase after a timeout or reset.
module ram_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_data,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  input  logic        mem_response,
  input  logic [31:0] mem_out
);

  typedef enum logic [2:0] {
    SETTLE,
    IDLE,
    WAIT_LOW,
    WAIT_HIGH,
    WAIT_SAME,
    RESP
  } state_t;

  // The counter counts failed samples; hitting this value on a failed
  // sample means TIMEOUT consecutive failures have now been seen.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] memData_q, memData_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic        memWr_q, memWr_d;
  logic [31:0] rspRdata_q, rspRdata_d;
  logic        rspErr_q, rspErr_d;
  logic [7:0]  toCnt_q, toCnt_d;
  logic        settleSeen_q, settleSeen_d;
  logic        toHit;
  logic        sameBus;

  assign toHit   = (toCnt_q == TO_LAST);
  // On a read the data field is not updated, so only address and direction
  // can differ from what is already on the bus.
  assign sameBus = (req_addr == memAddr_q) && (req_wr == memWr_q) &&
                   (!req_wr || (req_wdata == memData_q));

  // Next-state and bus/response update logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    memData_d    = memData_q;
    memAddr_d    = memAddr_q;
    memWr_d      = memWr_q;
    rspRdata_d   = rspRdata_q;
    rspErr_d     = rspErr_q;
    toCnt_d      = toCnt_q;
    settleSeen_d = settleSeen_q;
    req_ready    = 1'b0;

    case (state_q)
      SETTLE: begin
        if (mem_response) begin
          if (settleSeen_q) begin
            state_d      = IDLE;
            settleSeen_d = 1'b0;
          end else begin
            settleSeen_d = 1'b1;
          end
        end else begin
          settleSeen_d = 1'b0;
        end
      end

      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          memAddr_d = req_addr;
          memWr_d   = req_wr;
          if (req_wr) begin
            memData_d = req_wdata;
          end
          toCnt_d = 8'd0;
          state_d = sameBus ? WAIT_SAME : WAIT_LOW;
        end
      end

      WAIT_LOW: begin
        if (!mem_response) begin
          state_d = WAIT_HIGH;
          toCnt_d = 8'd0;
        end else if (toHit) begin
          state_d  = RESP;
          rspErr_d = 1'b1;
        end else begin
          toCnt_d = toCnt_q + 8'd1;
        end
      end

      WAIT_HIGH: begin
        if (mem_response) begin
          state_d  = RESP;
          rspErr_d = 1'b0;
          if (!memWr_q) begin
            rspRdata_d = mem_out;
          end
        end else if (toHit) begin
          state_d  = RESP;
          rspErr_d = 1'b1;
        end else begin
          toCnt_d = toCnt_q + 8'd1;
        end
      end

      WAIT_SAME: begin
        state_d  = RESP;
        rspErr_d = 1'b0;
        if (!memWr_q) begin
          rspRdata_d = mem_out;
        end
      end

      RESP: begin
        settleSeen_d = 1'b0;
        state_d      = rspErr_q ? SETTLE : IDLE;
      end

      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  // State, bus and response registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SETTLE;
      memData_q    <= 32'd0;
      memAddr_q    <= 32'd0;
      memWr_q      <= 1'b0;
      rspRdata_q   <= 32'd0;
      rspErr_q     <= 1'b0;
      toCnt_q      <= 8'd0;
      settleSeen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      memData_q    <= memData_d;
      memAddr_q    <= memAddr_d;
      memWr_q      <= memWr_d;
      rspRdata_q   <= rspRdata_d;
      rspErr_q     <= rspErr_d;
      toCnt_q      <= toCnt_d;
      settleSeen_q <= settleSeen_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & rspErr_q;
  assign rsp_rdata = rspRdata_q;
  assign mem_data  = memData_q;
  assign mem_addr  = memAddr_q;
  assign mem_wr    = memWr_q;

endmodule

// File: tb/tb_ram_master.sv
// Testbench for ram_master: behavioural negedge memory, directed requests,
// and a scoreboard monitor that checks every completion pulse.
module tb_ram_master;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_data;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic        mem_response;
  logic [31:0] mem_out;

  logic        forceEn;
  logic        forceVal;
  logic        memResp = 1'b1;
  logic [31:0] memOut = 32'd0;
  logic [64:0] lastBus = 65'd0;
  logic [31:0] memArr [256];

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t expQ[$];

  ram_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_data(mem_data),
    .mem_addr(mem_addr),
    .mem_wr(mem_wr),
    .mem_response(mem_response),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Posedge counter used to measure response latency.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Behavioural memory: a bus change drops the done flag, a stable bus executes.
  always @(negedge clk) begin
    if ({mem_wr, mem_addr, mem_data} != lastBus) begin
      memResp <= 1'b0;
      lastBus <= {mem_wr, mem_addr, mem_data};
    end else begin
      memResp <= 1'b1;
      if (mem_wr) memArr[mem_addr[7:0]] <= mem_data;
      else        memOut <= memArr[mem_addr[7:0]];
    end
  end

  assign mem_response = forceEn ? forceVal : memResp;
  assign mem_out      = memOut;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h want 0x%h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid !== 1'b0) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=%b want no response at t=%0t",
                 rsp_valid, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        checkOutput("rsp_latency", cycleCnt, e.due);
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] expRdata,
                               input logic expErr, input int lat, input bit track);
    int n = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got req_ready=%b want 1 within 50 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      e.rdata = expRdata;
      e.err   = expErr;
      e.due   = cycleCnt + 1 + lat;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("accept_mem_addr", mem_addr, addr);
    checkOutput("accept_mem_wr", {31'd0, mem_wr}, {31'd0, wr});
    if (wr) checkOutput("accept_mem_data", mem_data, data);
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drainQueue();
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    checkOutput({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_data"}, mem_data, 32'd0);
    checkOutput({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 32'd0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    forceEn   = 1'b1;
    forceVal  = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    checkResetValues("reset");

    // Settle with a steady done flag: ready after the 2nd posedge.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("settle_ready_1st", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("settle_ready_2nd", {31'd0, req_ready}, 32'd1);

    // Settle with a 0 sample after the 1st posedge: count restarts.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("glitch_ready_p1", {31'd0, req_ready}, 32'd0);
    forceVal = 1'b0;
    @(posedge clk); #1;
    checkOutput("glitch_ready_p2", {31'd0, req_ready}, 32'd0);
    forceVal = 1'b1;
    @(posedge clk); #1;
    checkOutput("glitch_ready_p3", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("glitch_ready_p4", {31'd0, req_ready}, 32'd1);
    forceEn = 1'b0;

    // Normal transactions: new bus -> latency 2, identical bus -> latency 1.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1, 1'b1);
    applyStimulus(1'b1, 32'h11, 32'h12345678, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    applyStimulus(1'b1, 32'h11, 32'h12345678, 32'hDEADBEEF, 1'b0, 1, 1'b1);
    applyStimulus(1'b0, 32'h11, 32'h0,        32'h12345678, 1'b0, 2, 1'b1);
    applyStimulus(1'b0, 32'h11, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1, 1'b1);
    checkOutput("read_keeps_data", mem_data, 32'h12345678);
    drainQueue();

    // Timeout: done flag stuck high, error response after TIMEOUT failed samples.
    forceEn  = 1'b1;
    forceVal = 1'b1;
    applyStimulus(1'b0, 32'h20, 32'h0, 32'h12345678, 1'b1, TIMEOUT, 1'b1);
    repeat (TIMEOUT) @(posedge clk);
    #1;
    forceVal = 1'b0;
    checkOutput("bus_after_timeout", mem_addr, 32'h20);

    // In SETTLE a held request must be ignored.
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'h44;
    req_wdata = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("settle_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    checkOutput("settle_hold_bus", mem_addr, 32'h20);
    req_valid = 1'b0;
    forceEn   = 1'b0;
    waitReady("settle_exit_ready");
    drainQueue();

    applyStimulus(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    drainQueue();

    // Reset while in WAIT_HIGH: immediate reset values, no completion pulse.
    applyStimulus(1'b1, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 2, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    waitReady("resume_ready");

    applyStimulus(1'b0, 32'h11, 32'h0, 32'h12345678, 1'b0, 2, 1'b1);
    drainQueue();
    checkOutput("queue_empty", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameter TIMEOUT, 16, max consecutive failed samples in a wait state before error; legal 1..255.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req_valid  in  1  client request present.
REQ-005 req_ready  out  1  master accepts a request this cycle.
REQ-006 req_wr  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  32  word address.
REQ-008 req_wdata  in  32  write data; ignored on reads.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  32  read data.
REQ-011 rsp_err  out  1  completion was a timeout; valid with rsp_valid.
REQ-012 mem_data  out  32  data to memory.
REQ-013 mem_addr  out  32  address to memory.
REQ-014 mem_wr  out  1  1 = write, 0 = read.
REQ-015 mem_response  in  1  memory done flag; 0 = busy.
REQ-016 mem_out  in  32  memory read data.

Function
REQ-017 Memory protocol: memory samples on negedge; a change in any of mem_data, mem_addr or mem_wr drops mem_response at that negedge; at the next negedge with the bus unchanged, memory executes and raises mem_response; an unchanged bus executes at the next negedge with mem_response staying 1.
REQ-018 mem_data, mem_addr and mem_wr shall be registered, change only on the posedge that accepts a request, and hold until the next acceptance.
REQ-019 States: SETTLE, IDLE, WAIT_LOW, WAIT_HIGH, WAIT_SAME, RESP.
REQ-020 req_ready shall be 1 only in IDLE; acceptance = req_valid & req_ready at posedge.
REQ-021 On acceptance: mem_addr <= req_addr; mem_wr <= req_wr; mem_data <= req_wdata if req_wr, else unchanged.
REQ-022 If the new bus value equals the currently driven bus value on all three fields, go to WAIT_SAME; otherwise go to WAIT_LOW.
REQ-023 WAIT_LOW: mem_response == 0 -> WAIT_HIGH with the timeout counter cleared.
REQ-024 WAIT_HIGH: mem_response == 1 -> RESP.
REQ-025 WAIT_SAME: unconditionally -> RESP at the next posedge.
REQ-026 Entering RESP from a read: rsp_rdata <= mem_out. Writes leave rsp_rdata unchanged.
REQ-027 Latency, accept edge to rsp_valid high: 2 cycles for a new bus value; 1 cycle for an identical bus value.
REQ-028 RESP: rsp_valid = 1 for exactly one cycle, then -> IDLE; rsp_err = 0 on a normal completion.
REQ-029 Timeout: 8-bit counter, cleared on entry to WAIT_LOW and WAIT_HIGH, incremented on each failed sample.
REQ-030 TIMEOUT consecutive failed samples -> RESP with rsp_err = 1, rsp_rdata unchanged, and then -> SETTLE instead of IDLE.
REQ-031 SETTLE: req_ready = 0; exit to IDLE after mem_response is sampled 1 on 2 consecutive posedges; any 0 sample restarts the count; no timeout.
REQ-032 The bus shall never change outside an acceptance edge; a request held on req_valid while req_ready = 0 has no effect.

Reset
REQ-033 rst_n low immediately forces: state SETTLE, settle and timeout counters 0, mem_data = mem_addr = 0, mem_wr = 0, req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
REQ-034 Reset mid-transaction abandons it with no rsp_valid pulse; after rst_n rises, operation resumes through SETTLE.

Verification
REQ-035 Reset release with mem_response = 1 steady -> req_ready rises after the 2nd posedge; with a 0 injected after the 1st posedge -> req_ready rises only after 2 further consecutive 1 samples.
REQ-036 Write addr 0x10, data 0xDEADBEEF, against a behavioural memory -> mem bus updated at the accept edge; rsp_valid pulse 2 cycles later; rsp_err = 0.
REQ-037 Read addr 0x10 -> rsp_rdata = 0xDEADBEEF, latency 2; immediately repeat the identical read -> WAIT_SAME path, latency 1, same data.
REQ-038 TIMEOUT = 4, mem_response stuck at 1, read addr 0x20 -> rsp_valid with rsp_err = 1 four cycles after acceptance; rsp_rdata unchanged; bus still 0x20; then SETTLE.
REQ-039 rst_n low while in WAIT_HIGH -> all outputs go to reset values without waiting for clk; no rsp_valid pulse.
